// File: rtl/rvc_pkg.sv
// Shared definitions for the RVC fetch path: aligner states and encoding constants.
package rvc_pkg;
  localparam int         HALF_W    = 16;
  localparam logic [1:0] RVC_LEN32 = 2'b11;

  typedef enum logic [1:0] {
    LO   = 2'd0,
    SKIP = 2'd1,
    RES  = 2'd2
  } align_state_t;
endpackage

// File: rtl/rvc_fetch_aligner.sv
// Splits sequential 32-bit fetch words into 16/32-bit instructions, one per
// cycle, carrying a residue halfword across word boundaries for straddles.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid_i,
  input  logic [31:0]     fetch_data_i,
  output logic            fetch_ready_o,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic            inst_is_rv_o,
  output logic [PC_W-1:0] inst_pc_o,
  input  logic            inst_ready_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] redirect_pc_i
);

  align_state_t          state;
  logic [HALF_W-1:0]     res;
  logic [PC_W-1:0]       res_pc;
  logic [PC_W-1:0]       word_pc;

  logic [HALF_W-1:0]     lo, hi;
  logic                  adv, accept, res_is32, lo_is32;
  logic                  out_vld;
  logic [31:0]           out_inst;
  logic                  out_rv;
  logic [PC_W-1:0]       out_pc;

  assign lo       = fetch_data_i[HALF_W-1:0];
  assign hi       = fetch_data_i[31:HALF_W];
  assign adv      = !inst_valid_o || inst_ready_i;
  assign res_is32 = (res[1:0] == RVC_LEN32);
  assign lo_is32  = (lo[1:0] == RVC_LEN32);
  assign accept   = fetch_valid_i && fetch_ready_o;

  // Ready depends only on state/residue/output occupancy, never on fetch_valid_i.
  always_comb begin
    fetch_ready_o = 1'b0;
    if (!flush_i) begin
      case (state)
        LO:      fetch_ready_o = adv;
        SKIP:    fetch_ready_o = 1'b1;
        RES:     fetch_ready_o = res_is32 ? adv : 1'b0;
        default: fetch_ready_o = 1'b0;
      endcase
    end
  end

  // Select the next instruction to present; SKIP never produces one.
  always_comb begin
    out_vld  = 1'b0;
    out_inst = 32'h0;
    out_rv   = 1'b0;
    out_pc   = word_pc;
    case (state)
      LO: begin
        out_vld  = accept;
        out_inst = lo_is32 ? {hi, lo} : {16'h0, lo};
        out_rv   = lo_is32;
        out_pc   = word_pc;
      end
      RES: begin
        out_vld  = res_is32 ? accept : adv;
        out_inst = res_is32 ? {lo, res} : {16'h0, res};
        out_rv   = res_is32;
        out_pc   = res_pc;
      end
      default: ;
    endcase
  end

  // Output register, residue tracking and PC sequencing; flush drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LO;
      word_pc      <= RESET_PC;
      res          <= '0;
      res_pc       <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_is_rv_o <= 1'b0;
      inst_pc_o    <= '0;
    end else if (flush_i) begin
      inst_valid_o <= 1'b0;
      word_pc      <= {redirect_pc_i[PC_W-1:2], 2'b00};
      state        <= redirect_pc_i[1] ? SKIP : LO;
    end else begin
      if (adv) begin
        inst_valid_o <= out_vld;
        if (out_vld) begin
          inst_o       <= out_inst;
          inst_is_rv_o <= out_rv;
          inst_pc_o    <= out_pc;
        end
      end
      case (state)
        LO: if (accept) begin
          word_pc <= word_pc + PC_W'(4);
          if (!lo_is32) begin
            res    <= hi;
            res_pc <= word_pc + PC_W'(2);
            state  <= RES;
          end
        end
        SKIP: if (accept) begin
          res     <= hi;
          res_pc  <= word_pc + PC_W'(2);
          word_pc <= word_pc + PC_W'(4);
          state   <= RES;
        end
        RES: begin
          if (res_is32) begin
            if (accept) begin
              res     <= hi;
              res_pc  <= word_pc + PC_W'(2);
              word_pc <= word_pc + PC_W'(4);
            end
          end else if (adv) begin
            state <= LO;
          end
        end
        default: state <= LO;
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed per-cycle vectors for the fetch aligner with hand-computed results.
module tb_rvc_fetch_aligner;
  localparam int PC_W = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_valid_i;
  logic [31:0]     fetch_data_i;
  logic            fetch_ready_o;
  logic            inst_valid_o;
  logic [31:0]     inst_o;
  logic            inst_is_rv_o;
  logic [PC_W-1:0] inst_pc_o;
  logic            inst_ready_i;
  logic            flush_i;
  logic [PC_W-1:0] redirect_pc_i;

  rvc_fetch_aligner #(.PC_W(PC_W), .RESET_PC(64'h1000)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_i(fetch_valid_i), .fetch_data_i(fetch_data_i),
    .fetch_ready_o(fetch_ready_o),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_is_rv_o(inst_is_rv_o),
    .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i),
    .flush_i(flush_i), .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            rst;
    logic            fv;
    logic [31:0]     fd;
    logic            rdy;
    logic            fl;
    logic [PC_W-1:0] rpc;
    logic            chk_fr;
    logic            exp_fr;
    logic            exp_v;
    logic            chk_f;   // compare fields even when valid is low (reset)
    logic [31:0]     exp_inst;
    logic            exp_rv;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic r, logic fv, logic [31:0] fd, logic rdy, logic fl,
                              logic [PC_W-1:0] rpc, logic cfr, logic efr, logic ev,
                              logic cf, logic [31:0] ei, logic erv, logic [PC_W-1:0] epc);
    vec_t t;
    t = '{rst:r, fv:fv, fd:fd, rdy:rdy, fl:fl, rpc:rpc, chk_fr:cfr, exp_fr:efr,
          exp_v:ev, chk_f:cf, exp_inst:ei, exp_rv:erv, exp_pc:epc};
    return t;
  endfunction

  initial begin
    rst = 1'b1; fetch_valid_i = 1'b0; fetch_data_i = '0; inst_ready_i = 1'b1;
    flush_i = 1'b0; redirect_pc_i = '0;

    //            rst fv fd            rdy fl rpc                    cfr efr v  cf inst          rv pc
    // reset state
    vecs[0]  = mk(1, 0, 32'h0,        1, 0, 64'h0,                 0, 0, 0, 1, 32'h0,        0, 64'h0);
    // two compressed in one word; second cycle refuses the next word
    vecs[1]  = mk(0, 1, 32'h45150001, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00000001, 0, 64'h1000);
    vecs[2]  = mk(0, 1, 32'h00A50513, 1, 0, 64'h0,                 1, 0, 1, 1, 32'h00004515, 0, 64'h1002);
    // aligned 32-bit
    vecs[3]  = mk(0, 1, 32'h00A50513, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00A50513, 1, 64'h1004);
    // straddle
    vecs[4]  = mk(0, 1, 32'h05130001, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00000001, 0, 64'h1008);
    vecs[5]  = mk(0, 1, 32'h450100A5, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00A50513, 1, 64'h100A);
    vecs[6]  = mk(0, 0, 32'h0,        1, 0, 64'h0,                 1, 0, 1, 1, 32'h00004501, 0, 64'h100E);
    vecs[7]  = mk(0, 0, 32'h0,        1, 0, 64'h0,                 1, 1, 0, 0, 32'h0,        0, 64'h0);
    // back-pressure during a straddle
    vecs[8]  = mk(0, 1, 32'h05130001, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00000001, 0, 64'h1010);
    vecs[9]  = mk(0, 1, 32'h450100A5, 0, 0, 64'h0,                 1, 0, 1, 1, 32'h00000001, 0, 64'h1010);
    vecs[10] = mk(0, 1, 32'h450100A5, 0, 0, 64'h0,                 1, 0, 1, 1, 32'h00000001, 0, 64'h1010);
    vecs[11] = mk(0, 1, 32'h450100A5, 0, 0, 64'h0,                 1, 0, 1, 1, 32'h00000001, 0, 64'h1010);
    vecs[12] = mk(0, 1, 32'h450100A5, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00A50513, 1, 64'h1012);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 64'h0,                 1, 0, 1, 1, 32'h00A50513, 1, 64'h1012);
    vecs[14] = mk(0, 0, 32'h0,        1, 0, 64'h0,                 1, 0, 1, 1, 32'h00004501, 0, 64'h1016);
    // held output, then flush with ready high: discarded, word dropped
    vecs[15] = mk(0, 1, 32'h05130001, 0, 0, 64'h0,                 1, 0, 1, 1, 32'h00004501, 0, 64'h1016);
    vecs[16] = mk(0, 1, 32'h05130001, 1, 1, 64'h2002,              1, 0, 0, 0, 32'h0,        0, 64'h0);
    vecs[17] = mk(0, 1, 32'h4515FFFF, 1, 0, 64'h0,                 1, 1, 0, 0, 32'h0,        0, 64'h0);
    vecs[18] = mk(0, 0, 32'h0,        1, 0, 64'h0,                 1, 0, 1, 1, 32'h00004515, 0, 64'h2002);
    // redirect with bit 0 set: ignored, aligned target
    vecs[19] = mk(0, 0, 32'h0,        1, 1, 64'h3001,              1, 0, 0, 0, 32'h0,        0, 64'h0);
    vecs[20] = mk(0, 1, 32'h12345513, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h12345513, 1, 64'h3000);
    // reset while a residue is held
    vecs[21] = mk(0, 1, 32'h05130001, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00000001, 0, 64'h3004);
    vecs[22] = mk(1, 1, 32'h450100A5, 1, 0, 64'h0,                 0, 0, 0, 1, 32'h0,        0, 64'h0);
    vecs[23] = mk(0, 1, 32'h00A50513, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00A50513, 1, 64'h1000);
    // PC wrap-around through a SKIP straddle
    vecs[24] = mk(0, 0, 32'h0,        1, 1, 64'hFFFFFFFFFFFFFFFE,  1, 0, 0, 0, 32'h0,        0, 64'h0);
    vecs[25] = mk(0, 1, 32'h0513FFFF, 1, 0, 64'h0,                 1, 1, 0, 0, 32'h0,        0, 64'h0);
    vecs[26] = mk(0, 1, 32'h450100A5, 1, 0, 64'h0,                 1, 1, 1, 1, 32'h00A50513, 1, 64'hFFFFFFFFFFFFFFFE);
    vecs[27] = mk(0, 0, 32'h0,        1, 0, 64'h0,                 1, 0, 1, 1, 32'h00004501, 0, 64'h2);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; fetch_valid_i = vecs[i].fv; fetch_data_i = vecs[i].fd;
      inst_ready_i = vecs[i].rdy; flush_i = vecs[i].fl; redirect_pc_i = vecs[i].rpc;
      #1;
      if (vecs[i].chk_fr) begin
        checks++;
        if (fetch_ready_o !== vecs[i].exp_fr) begin
          failures++;
          $display("FAIL vec%0d fetch_ready: got %b want %b", i, fetch_ready_o, vecs[i].exp_fr);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (inst_valid_o !== vecs[i].exp_v) begin
        failures++;
        $display("FAIL vec%0d inst_valid: got %b want %b", i, inst_valid_o, vecs[i].exp_v);
      end
      if (vecs[i].chk_f) begin
        checks++;
        if (inst_o !== vecs[i].exp_inst || inst_is_rv_o !== vecs[i].exp_rv ||
            inst_pc_o !== vecs[i].exp_pc) begin
          failures++;
          $display("FAIL vec%0d fields: got inst=%h rv=%b pc=%h want inst=%h rv=%b pc=%h",
                   i, inst_o, inst_is_rv_o, inst_pc_o,
                   vecs[i].exp_inst, vecs[i].exp_rv, vecs[i].exp_pc);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
